bitmask_frame_reader: RTL and testbench
=======================================

// Module: bitmask_frame_reader
// PURPOSE
//  Reads a completed 1-bit thresholded frame back out of the SPRAM bitmask buffer. The capture
//  path fills the buffer in raster order at addresses 0..H_PIXELS*V_LINES-1.
//  Packs 8 pixels per byte and streams bytes over a valid/ready interface to the MCU link (SPI TX).
//  Flags end-of-line and end-of-frame. Runs in the system clock domain.
//  The top level must block new capture writes while rd_busy=1.
// PARAMETERS
//  H_PIXELS  320  pixels per line; must be a multiple of 8
//  V_LINES   240  lines per frame
//  ADDR_W    17   SPRAM pixel address width; must satisfy 2**ADDR_W >= H_PIXELS*V_LINES
// PORTS
//  clk        in   1       system clock; the single clock of this block
//  nreset     in   1       asynchronous, active-low reset
//  start      in   1       1-cycle pulse: begin reading a frame; already synchronised into clk
//  abort      in   1       synchronous: drop the current frame and return to IDLE
//  rd_en      out  1       SPRAM read strobe
//  rd_addr    out  ADDR_W  SPRAM pixel address
//  rd_data    in   1       bitmask pixel; valid exactly 1 clk after the rd_en cycle
//  out_data   out  8       packed byte; bit7 = leftmost pixel
//  out_valid  out  1       out_data, out_eol and out_eof are valid
//  out_ready  in   1       downstream accepts the byte when out_valid & out_ready
//  out_eol    out  1       high with the last byte of each line (byte index H_PIXELS/8-1)
//  out_eof    out  1       high with the final byte of the frame; out_eol is also high on it
//  rd_busy    out  1       high from the cycle after an accepted start until frame_done
//  frame_done out  1       1-cycle pulse after the final byte is accepted
// BEHAVIOUR
//  Reset values: rd_en=0, rd_addr=0, out_data=0, out_valid=0, out_eol=0, out_eof=0, rd_busy=0,
//   frame_done=0. Internal state: IDLE, bit_cnt=0, byte_in_line=0, line=0.
//  FSM states: IDLE, FETCH, DRAIN, EMIT.
//   IDLE : start=1 -> FETCH, rd_addr=0, rd_busy=1. start is ignored in every other state.
//   FETCH: rd_en=1 for 8 consecutive cycles at rd_addr, rd_addr+1, ... rd_addr+7.
//          rd_addr increments once per issued read. After the 8th issue -> DRAIN.
//   DRAIN: one cycle; captures the 8th returned bit; loads out_data; sets out_valid=1 -> EMIT.
//   Capture pipeline: rd_en registered into cap_v. On cap_v=1, shift left: sh <= {sh[6:0], rd_data}.
//   EMIT : out_data, out_eol and out_eof are held stable while out_valid=1 and out_ready=0.
//          On out_valid & out_ready: out_valid=0. If the byte was eof -> IDLE with frame_done=1
//          and rd_busy=0 in the same cycle. Otherwise -> FETCH on the next cycle.
//  Throughput: 10 clk per byte when out_ready is held at 1 (8 FETCH + DRAIN + EMIT).
//   First out_valid occurs 10 clk after start.
//  Counters:
//   byte_in_line counts 0..H_PIXELS/8-1, wraps to 0 and increments line.
//   line counts 0..V_LINES-1.
//   eol = (byte_in_line == H_PIXELS/8-1). eof = eol & (line == V_LINES-1).
//  Address: after the final pixel (H_PIXELS*V_LINES-1) is issued, rd_addr returns to 0.
//   It never exceeds the final pixel address.
//  abort: highest priority in every state. Next cycle the block is in IDLE with out_valid=0,
//   rd_en=0, rd_busy=0 and counters cleared. frame_done is not pulsed. Bits still in flight
//   are discarded. abort in IDLE has no effect.
//  abort together with start in IDLE: abort wins, start is dropped.
//  nreset asserted mid-frame: all outputs go to reset values immediately. No partial byte is emitted.
//  out_valid never drops without a handshake, except on abort or reset.
// STRUCTURE
//  Shared package cam_pkg:
//   FRAME_W=320, FRAME_H=240, FRAME_PIXELS=76800, PIX_ADDR_W=17, BYTES_PER_LINE=40.
//   Typedef of the FSM state enum.
//  One sub-module, bit_packer: the 8-bit shift register plus cap_v pipeline.
//   Inputs: bit_valid, bit_in, clear. Outputs: byte, byte_full.
//  The FSM and the counters stay in this module.
// TESTING
//  1 Checkerboard SPRAM model (pixel = x^y parity), out_ready=1 -> 9600 bytes alternating
//    0xAA/0x55 per line. eol on every 40th byte. eof only on byte 9599. A single frame_done.
//  2 All-ones frame with out_ready toggling on a random 30% duty -> every byte is 0xFF.
//    out_data is stable while out_ready=0. Exactly 9600 handshakes.
//  3 start pulsed again mid-frame -> ignored: address sequence is unbroken and byte count
//    stays 9600.
//  4 abort asserted during FETCH of byte 100 -> next cycle out_valid=0, rd_busy=0,
//    no frame_done. A following start re-reads from rd_addr=0.
//  5 nreset pulsed during EMIT -> all outputs at reset values the same cycle. Fresh start
//    gives first byte = pixels 0..7.
//  6 Ramp model (pixel = 1 iff addr>=76792), out_ready=1 -> last byte is 0xFF with eof=1.
//    All earlier bytes are 0x00. rd_addr=0 after frame_done.

Source files
------------

// File: rtl/cam_pkg.sv
// Camera pipeline constants shared across the capture and readback blocks,
// plus the state type of the bitmask frame reader.
package cam_pkg;
   localparam int FRAME_W        = 320;
   localparam int FRAME_H        = 240;
   localparam int FRAME_PIXELS   = FRAME_W * FRAME_H;
   localparam int PIX_ADDR_W     = 17;
   localparam int BYTES_PER_LINE = FRAME_W / 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRAIN,
      ST_EMIT
   } rd_state_t;
endpackage

// File: rtl/bitmask_frame_reader_bit_packer.sv
// Collects SPRAM read returns (one clock behind the strobe) into a byte, leftmost pixel in bit 7.
module bit_packer (
   input  logic       clk,
   input  logic       nreset,
   input  logic       clear,
   input  logic       bit_valid,
   input  logic       bit_in,
   output logic [7:0] packed_byte,
   output logic       byte_full
);
   logic       cap_v;
   logic [6:0] sh;
   logic [2:0] cnt;

   // Only 7 bits are stored; the 8th arrives live on bit_in in the cycle the byte completes.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         cap_v <= 1'b0;
         sh    <= '0;
         cnt   <= '0;
      end else if (clear) begin
         cap_v <= 1'b0;
         sh    <= '0;
         cnt   <= '0;
      end else begin
         cap_v <= bit_valid;
         if (cap_v) begin
            sh  <= {sh[5:0], bit_in};
            cnt <= cnt + 3'd1;
         end
      end
   end

   assign packed_byte = {sh, bit_in};
   assign byte_full   = cap_v && (cnt == 3'd7);
endmodule

// File: rtl/bitmask_frame_reader.sv
// Streams a stored 1-bit frame out of SPRAM as packed bytes with line/frame markers.
module bitmask_frame_reader
   import cam_pkg::*;
#(
   parameter int H_PIXELS = FRAME_W,
   parameter int V_LINES  = FRAME_H,
   parameter int ADDR_W   = PIX_ADDR_W
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              start,
   input  logic              abort,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_data,
   output logic [7:0]        out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_eol,
   output logic              out_eof,
   output logic              rd_busy,
   output logic              frame_done
);
   localparam int BPL   = H_PIXELS / 8;
   localparam int BIL_W = (BPL > 1) ? $clog2(BPL) : 1;
   localparam int LN_W  = (V_LINES > 1) ? $clog2(V_LINES) : 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_PIXELS * V_LINES - 1);

   rd_state_t        state, state_nxt;
   logic [2:0]       fcnt;
   logic [BIL_W-1:0] byte_in_line;
   logic [LN_W-1:0]  line_cnt;
   logic             eol, eof;
   logic [7:0]       packed_byte;
   logic             byte_full;

   bit_packer u_packer (
      .clk         (clk),
      .nreset      (nreset),
      .clear       (abort),
      .bit_valid   (rd_en),
      .bit_in      (rd_data),
      .packed_byte (packed_byte),
      .byte_full   (byte_full)
   );

   assign eol       = (byte_in_line == BIL_W'(BPL - 1));
   assign eof       = eol && (line_cnt == LN_W'(V_LINES - 1));
   assign rd_en     = (state == ST_FETCH);
   assign out_valid = (state == ST_EMIT);
   assign rd_busy   = (state != ST_IDLE);

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_FETCH;
         ST_FETCH: if (fcnt == 3'd7) state_nxt = ST_DRAIN;
         ST_DRAIN: if (byte_full) state_nxt = ST_EMIT;
         ST_EMIT:  if (out_ready) state_nxt = out_eof ? ST_IDLE : ST_FETCH;
         default:  state_nxt = ST_IDLE;
      endcase
      if (abort) state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         rd_addr      <= '0;
         fcnt         <= '0;
         byte_in_line <= '0;
         line_cnt     <= '0;
         out_data     <= '0;
         out_eol      <= 1'b0;
         out_eof      <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (abort) begin
            rd_addr      <= '0;
            fcnt         <= '0;
            byte_in_line <= '0;
            line_cnt     <= '0;
         end else begin
            case (state)
               ST_IDLE: if (start) begin
                  rd_addr <= '0;
                  fcnt    <= '0;
               end
               ST_FETCH: begin
                  rd_addr <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;
                  fcnt    <= fcnt + 3'd1;
               end
               ST_DRAIN: if (byte_full) begin
                  out_data <= packed_byte;
                  out_eol  <= eol;
                  out_eof  <= eof;
               end
               ST_EMIT: if (out_ready) begin
                  frame_done <= out_eof;
                  // Position counters advance per accepted byte and wrap naturally at end of frame.
                  if (eol) begin
                     byte_in_line <= '0;
                     line_cnt     <= (line_cnt == LN_W'(V_LINES - 1)) ? '0 : line_cnt + 1'b1;
                  end else begin
                     byte_in_line <= byte_in_line + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_bitmask_frame_reader.sv
// Directed bench for bitmask_frame_reader on a reduced 32x6 frame with a byte-level reference model.
module tb_bitmask_frame_reader;
   localparam int H      = 32;
   localparam int V      = 6;
   localparam int AW     = 8;
   localparam int NPIX   = H * V;
   localparam int BPL    = H / 8;
   localparam int NBYTES = NPIX / 8;

   logic          clk = 1'b0;
   logic          nreset, start, abort, out_ready;
   logic          rd_en, out_valid, out_eol, out_eof, rd_busy, frame_done;
   logic          rd_data = 1'b0;
   logic [AW-1:0] rd_addr;
   logic [7:0]    out_data;

   always #5 clk = ~clk;

   bitmask_frame_reader #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
      .clk(clk), .nreset(nreset), .start(start), .abort(abort),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_eol(out_eol), .out_eof(out_eof), .rd_busy(rd_busy), .frame_done(frame_done)
   );

   logic mem [NPIX];
   always @(posedge clk)
      if (rd_en) rd_data <= (int'(rd_addr) < NPIX) ? mem[int'(rd_addr)] : 1'b0;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fill(input int pat);
      for (int a = 0; a < NPIX; a++) begin
         case (pat)
            0:       mem[a] = (((a % H) ^ (a / H)) & 1) != 0;
            1:       mem[a] = 1'b1;
            default: mem[a] = (a >= NPIX - 8);
         endcase
      end
   endtask

   function automatic logic [7:0] model_byte(input int idx);
      logic [7:0] b;
      for (int j = 0; j < 8; j++) b[7-j] = mem[8*idx + j];
      return b;
   endfunction

   int         exp_idx = 0, exp_addr = 0, hs_cnt = 0, fd_cnt = 0;
   logic [7:0] got     [NBYTES];
   logic       got_eol [NBYTES];
   logic       got_eof [NBYTES];
   logic       stall = 1'b0, last_eof = 1'b0;
   logic [7:0] stall_data;
   logic       stall_eol, stall_eof;

   always @(negedge clk) begin
      if (frame_done) begin
         chk("frame_done_after_eof", last_eof, 1);
         fd_cnt++;
         last_eof = 1'b0;
      end
      if (!nreset || abort) begin
         exp_idx  = 0;
         exp_addr = 0;
         stall    = 1'b0;
         last_eof = 1'b0;
      end else begin
         if (stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, stall_data);
            chk("hold_eol", out_eol, stall_eol);
            chk("hold_eof", out_eof, stall_eof);
         end
         if (rd_en) begin
            chk("rd_addr", rd_addr, exp_addr);
            exp_addr = (exp_addr + 1) % NPIX;
         end
         if (out_valid && out_ready) begin
            chk("out_data", out_data, model_byte(exp_idx));
            chk("out_eol", out_eol, (exp_idx % BPL) == BPL - 1);
            chk("out_eof", out_eof, exp_idx == NBYTES - 1);
            got[exp_idx]     = out_data;
            got_eol[exp_idx] = out_eol;
            got_eof[exp_idx] = out_eof;
            last_eof         = out_eof;
            hs_cnt++;
            exp_idx = (exp_idx + 1) % NBYTES;
         end
         stall      = out_valid && !out_ready;
         stall_data = out_data;
         stall_eol  = out_eol;
         stall_eof  = out_eof;
      end
   end

   // mode 0: out_ready held high; mode 1: out_ready high on ~30% of cycles.
   task automatic run_frame(input int mode, input int restart_at, input string tag, output int lat);
      int hs0, fd0, cyc;
      hs0 = hs_cnt;
      fd0 = fd_cnt;
      lat = 0;
      @(posedge clk); #1;
      start     = 1'b1;
      out_ready = (mode == 0);
      @(posedge clk); #1;
      start = 1'b0;
      cyc   = 1;
      while (fd_cnt == fd0 && cyc < 4000) begin
         @(posedge clk); #1;
         cyc++;
         if (out_valid && lat == 0) lat = cyc;
         out_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
         start     = (cyc == restart_at);
      end
      start     = 1'b0;
      out_ready = 1'b1;
      chk({tag, "_timeout"}, cyc < 4000, 1);
      chk({tag, "_rd_busy_done"}, rd_busy, 0);
      chk({tag, "_rd_addr_done"}, rd_addr, 0);
      repeat (5) @(posedge clk);
      #1;
      chk({tag, "_bytes"}, hs_cnt - hs0, NBYTES);
      chk({tag, "_frame_done_count"}, fd_cnt - fd0, 1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rd_en"}, rd_en, 0);
      chk({tag, "_rd_addr"}, rd_addr, 0);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_eol"}, out_eol, 0);
      chk({tag, "_out_eof"}, out_eof, 0);
      chk({tag, "_rd_busy"}, rd_busy, 0);
      chk({tag, "_frame_done"}, frame_done, 0);
   endtask

   initial begin
      int lat, hs0, fd0, cyc;
      nreset = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
      fill(0);
      #12;
      chk_reset_outputs("reset");
      @(posedge clk); #1;
      nreset = 1'b1;

      // checkerboard, ready always high
      fill(0);
      run_frame(0, 0, "t1", lat);
      chk("t1_latency", lat, 10);
      chk("t1_byte0", got[0], 8'h55);
      chk("t1_byte4", got[4], 8'hAA);
      chk("t1_eol_byte3", got_eol[3], 1);
      chk("t1_eol_byte2", got_eol[2], 0);
      chk("t1_eof_byte19", got_eof[19], 0);
      chk("t1_eof_last", got_eof[NBYTES-1], 1);

      // all ones, throttled sink
      fill(1);
      run_frame(1, 0, "t2", lat);
      chk("t2_byte10", got[10], 8'hFF);

      // second start mid-frame must be ignored
      fill(0);
      run_frame(0, 55, "t3", lat);

      // abort during FETCH of byte 10
      hs0 = hs_cnt; fd0 = fd_cnt;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      cyc = 0;
      while (hs_cnt - hs0 < 10 && cyc < 1000) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("t4_reach_byte10", hs_cnt - hs0, 10);
      @(posedge clk); #1;
      chk("t4_in_fetch", rd_en, 1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("t4_out_valid", out_valid, 0);
      chk("t4_rd_busy", rd_busy, 0);
      chk("t4_rd_en", rd_en, 0);
      chk("t4_rd_addr", rd_addr, 0);
      repeat (20) @(posedge clk);
      #1;
      chk("t4_no_frame_done", fd_cnt - fd0, 0);
      run_frame(0, 0, "t4b", lat);
      chk("t4b_latency", lat, 10);
      chk("t4b_byte0", got[0], 8'h55);

      // reset pulsed while a byte is waiting in EMIT
      out_ready = 1'b0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("t5_in_emit", out_valid, 1);
      #2 nreset = 1'b0;
      #1 chk_reset_outputs("t5");
      repeat (2) @(posedge clk);
      #1;
      nreset    = 1'b1;
      out_ready = 1'b1;
      run_frame(0, 0, "t5b", lat);
      chk("t5b_first_byte", got[0], 8'h55);

      // ramp: only the last 8 pixels set
      fill(2);
      run_frame(0, 0, "t6", lat);
      chk("t6_last_byte", got[NBYTES-1], 8'hFF);
      chk("t6_last_eof", got_eof[NBYTES-1], 1);
      chk("t6_prev_byte", got[NBYTES-2], 8'h00);
      chk("t6_first_byte", got[0], 8'h00);

      // abort together with start in IDLE: start dropped
      fd0 = fd_cnt;
      @(posedge clk); #1;
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      chk("t7_rd_busy", rd_busy, 0);
      chk("t7_rd_en", rd_en, 0);
      repeat (15) @(posedge clk);
      #1;
      chk("t7_still_idle", out_valid, 0);
      chk("t7_no_frame_done", fd_cnt - fd0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
